// File: rtl/pwm_stream_scheduler.sv
// pwm_stream_scheduler: round-robin arbiter that turns each granted duty request
// into a burst of repeated PWM periods on a single shared stream output.
module pwm_stream_scheduler #(
    parameter  int NUM_REQ  = 4,
    parameter  int DATA_W   = 5,
    parameter  int REPEAT_W = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         in_clock,
    input  logic                         in_reset,
    input  logic                         in_enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*REPEAT_W-1:0]  req_repeat,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         pwm_valid,
    output logic [DATA_W-1:0]            pwm_data,
    input  logic                         pwm_ready,
    output logic                         busy,
    output logic [ID_W-1:0]              grant_id
);
    typedef enum logic {ARB, SEND} state_t;
    state_t state, state_next;
    logic [ID_W-1:0] rr_ptr, winner, next_ptr;
    logic [REPEAT_W-1:0] remaining, win_repeat;
    logic found, grant, hs, last;
    int j;
    // Scan offsets high to low so the lowest offset from rr_ptr ends up as winner
    always_comb begin
        found = 1'b0;
        winner = '0;
        j = 0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            j = int'(rr_ptr) + o;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (req_valid[j]) begin
                found = 1'b1;
                winner = ID_W'(j);
            end
        end
    end
    assign grant      = state == ARB && in_enable && found && !in_reset;
    assign req_ready  = grant ? NUM_REQ'(1) << winner : '0;
    assign win_repeat = req_repeat[winner*REPEAT_W +: REPEAT_W];
    assign hs         = state == SEND && pwm_ready;
    assign last       = remaining == REPEAT_W'(1);
    assign next_ptr   = grant_id == ID_W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    always_comb begin
        state_next = state;
        if (state == ARB)
            state_next = grant ? SEND : ARB;
        else
            state_next = hs && last ? ARB : SEND;
    end
    always_ff @(posedge in_clock) begin
        if (in_reset)
            state <= ARB;
        else
            state <= state_next;
    end
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            pwm_valid <= 1'b0;
            pwm_data  <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
        end else if (grant) begin
            pwm_data  <= req_data[winner*DATA_W +: DATA_W];
            remaining <= win_repeat == '0 ? REPEAT_W'(1) : win_repeat;
            grant_id  <= winner;
            pwm_valid <= 1'b1;
            busy      <= 1'b1;
        end else if (hs) begin
            if (last) begin
                pwm_valid <= 1'b0;
                busy      <= 1'b0;
                rr_ptr    <= next_ptr;
            end else begin
                remaining <= remaining - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_stream_scheduler.sv
// tb_pwm_stream_scheduler: directed scenarios plus random traffic, checked every
// cycle against a burst-level model of the scheduler.
module tb_pwm_stream_scheduler;
    localparam int N = 4, DW = 5, RW = 4, IW = 2;
    logic in_clock = 1'b0, in_reset = 1'b1, in_enable = 1'b0, pwm_ready = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*RW-1:0] req_repeat = '0;
    logic [N-1:0] req_ready;
    logic pwm_valid, busy;
    logic [DW-1:0] pwm_data;
    logic [IW-1:0] grant_id;
    pwm_stream_scheduler #(.NUM_REQ(N), .DATA_W(DW), .REPEAT_W(RW)) dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_enable(in_enable),
        .req_valid(req_valid), .req_data(req_data), .req_repeat(req_repeat),
        .req_ready(req_ready), .pwm_valid(pwm_valid), .pwm_data(pwm_data),
        .pwm_ready(pwm_ready), .busy(busy), .grant_id(grant_id)
    );
    always #5 in_clock = ~in_clock;
    int n_tests = 0, n_fail = 0;
    bit m_busy = 0, gen_mode = 1, consume = 0;
    int m_rem = 0, m_data = 0, m_gid = 0, m_rr = 0, gen_cnt = 0, hs_cnt = 0, cyc = 0;
    int grants[$], hs_data[$], hs_cyc[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        if (in_reset || m_busy || !in_enable) return r;
        for (int o = 0; o < N; o++) begin
            int k = (m_rr + o) % N;
            if (req_valid[k]) begin
                r[k] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction
    task automatic step();
        logic [N-1:0] er;
        int k;
        @(negedge in_clock);
        er = exp_ready();
        check("req_ready", req_ready, er);
        check("pwm_valid", pwm_valid, m_busy);
        check("pwm_data", pwm_data, m_data);
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_gid);
        if (pwm_valid && pwm_ready && !in_reset) begin
            hs_data.push_back(pwm_data);
            hs_cyc.push_back(cyc);
        end
        @(posedge in_clock);
        cyc++;
        k = -1;
        for (int i = 0; i < N; i++) if (er[i]) k = i;
        if (in_reset) begin
            m_busy = 0; m_rem = 0; m_data = 0; m_gid = 0; m_rr = 0;
        end else if (!m_busy) begin
            if (k >= 0) begin
                grants.push_back(k);
                m_busy = 1;
                m_data = (req_data >> (k * DW)) & ((1 << DW) - 1);
                m_rem = (req_repeat >> (k * RW)) & ((1 << RW) - 1);
                if (m_rem == 0) m_rem = 1;
                m_gid = k;
            end
        end else if (pwm_ready) begin
            hs_cnt++;
            gen_cnt = 31;
            if (m_rem == 1) begin
                m_busy = 0;
                m_rr = (m_gid + 1) % N;
            end else m_rem--;
        end else if (gen_cnt > 0) gen_cnt--;
        #1;
        if (k >= 0 && consume) req_valid[k] = 1'b0;
        if (gen_mode) pwm_ready = gen_cnt == 0;
    endtask
    task automatic set_req(input int i, input int d, input int r);
        req_data[i*DW +: DW] = DW'(d);
        req_repeat[i*RW +: RW] = RW'(r);
    endtask
    task automatic do_reset();
        in_reset = 1'b1;
        step();
        step();
        in_reset = 1'b0;
    endtask
    task automatic wait_idle(input string tag, input int limit);
        int i = 0;
        while (m_busy && i < limit) begin
            step();
            i++;
        end
        check(tag, m_busy, 0);
    endtask
    initial begin
        int g0;
        do_reset();
        check("rst_valid", pwm_valid, 0);
        check("rst_busy", busy, 0);
        // 1: single requester, repeat 3
        in_enable = 1; consume = 1; set_req(0, 10, 3); req_valid = 4'b0001;
        hs_cnt = 0; grants.delete(); hs_data.delete(); hs_cyc.delete();
        for (int i = 0; i < 10 && !m_busy; i++) step();
        wait_idle("t1_done", 200);
        check("t1_grants", grants.size(), 1);
        check("t1_hs", hs_cnt, 3);
        check("t1_gid", grant_id, 0);
        check("t1_nhs", hs_data.size(), 3);
        if (hs_data.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t1_data", hs_data[i], 10);
            check("t1_gap1", hs_cyc[1] - hs_cyc[0], 32);
            check("t1_gap2", hs_cyc[2] - hs_cyc[1], 32);
        end
        // 2: all valid, repeat 1, round-robin order from reset
        do_reset();
        consume = 0; gen_mode = 0; pwm_ready = 1;
        for (int i = 0; i < N; i++) set_req(i, i + 1, 1);
        req_valid = '1; grants.delete(); hs_data.delete();
        for (int i = 0; i < 100 && grants.size() < 5; i++) step();
        req_valid = '0;
        wait_idle("t2_done", 50);
        check("t2_ngrants", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("t2_order", grants[i], i % N);
        for (int i = 0; i < 5 && i < hs_data.size(); i++) check("t2_data", hs_data[i], i % N + 1);
        // 3: repeat 0 on requester 2 gives exactly one period
        gen_mode = 1; consume = 1; set_req(2, 17, 0); req_valid = 4'b0100; hs_cnt = 0;
        for (int i = 0; i < 10 && !m_busy; i++) step();
        wait_idle("t3_done", 100);
        check("t3_hs", hs_cnt, 1);
        check("t3_gid", grant_id, 2);
        // 4: ready held low for 5 cycles mid-burst
        gen_mode = 0; pwm_ready = 0; set_req(1, 7, 2); req_valid = 4'b0010; hs_cnt = 0;
        for (int i = 0; i < 10 && !m_busy; i++) step();
        for (int i = 0; i < 5; i++) step();
        check("t4_valid", pwm_valid, 1);
        check("t4_data", pwm_data, 7);
        check("t4_nohs", hs_cnt, 0);
        pwm_ready = 1;
        wait_idle("t4_done", 20);
        check("t4_hs", hs_cnt, 2);
        // 5: enable gating
        gen_mode = 1; in_enable = 0; req_valid = 4'b0011; g0 = grants.size();
        for (int i = 0; i < 10; i++) step();
        check("t5_nogrant", grants.size(), g0);
        req_valid = 4'b0001; set_req(0, 3, 2); in_enable = 1; hs_cnt = 0;
        for (int i = 0; i < 10 && !m_busy; i++) step();
        in_enable = 0; req_valid = 4'b0011;
        for (int i = 0; i < 100; i++) step();
        check("t5_hs", hs_cnt, 2);
        check("t5_hold", grants.size(), g0 + 1);
        in_enable = 1;
        for (int i = 0; i < 5; i++) step();
        check("t5_regrant", grants.size() > g0 + 1, 1);
        wait_idle("t5_done", 200);
        // 6: reset mid-burst, then requester 0 wins first
        consume = 0; set_req(0, 9, 3); req_valid = 4'b0001; hs_cnt = 0;
        for (int i = 0; i < 200 && hs_cnt < 1; i++) step();
        for (int i = 0; i < 10; i++) step();
        req_valid = '1;
        in_reset = 1;
        step();
        in_reset = 0;
        check("t6_valid", pwm_valid, 0);
        check("t6_busy", busy, 0);
        grants.delete();
        for (int i = 0; i < 5 && grants.size() == 0; i++) step();
        check("t6_first", grants.size() > 0 ? grants[0] : -1, 0);
        req_valid = '0;
        wait_idle("t6_done", 100);
        // random traffic
        gen_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            req_valid = N'($urandom);
            req_data = (N*DW)'({$urandom, $urandom});
            req_repeat = (N*RW)'($urandom);
            in_enable = $urandom_range(0, 9) != 0;
            pwm_ready = $urandom_range(0, 1) != 0;
            consume = $urandom_range(0, 1) != 0;
            in_reset = $urandom_range(0, 99) == 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
